// File: rtl/interrupt_sequencer_pkg.sv
// Shared types and constants for the interrupt entry/return sequencer.
package interrupt_sequencer_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_PUSH_HI,
    ST_PUSH_LO,
    ST_PUSH_FL,
    ST_VEC_LO,
    ST_VEC_HI,
    ST_POP_FL,
    ST_POP_LO,
    ST_POP_HI,
    ST_JUMP
  } state_t;

  // Which way the sequence is going; held from IDLE departure through JUMP.
  typedef enum logic {
    DIR_ENTRY  = 1'b0,
    DIR_RETURN = 1'b1
  } dir_t;

  // Injected micro-op encodings seen by the ID/EX buffer.
  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_PUSH = 3'd1;
  localparam logic [2:0] OP_POP  = 3'd2;
  localparam logic [2:0] OP_LOAD = 3'd3;

  // Flag bit positions inside {NF,CF,ZF}.
  localparam int FLAG_NF = 2;
  localparam int FLAG_CF = 1;
  localparam int FLAG_ZF = 0;

  // Drain counter width; comfortably covers any realistic pipeline depth.
  localparam int CNT_W = 8;

  // Stack word holding the architectural flags.
  function automatic logic [15:0] flags_word(input logic [2:0] flags);
    return {13'b0, flags};
  endfunction

endpackage

// File: rtl/interrupt_sequencer_if.sv
// Pipeline-side signal bundle of the interrupt sequencer.
// master = sequencer, slave = pipeline (decode, fetch, memory stage).
interface interrupt_sequencer_if;

  logic        INT_Req;
  logic        RTI_Dec;
  logic        Pipe_Busy;
  logic [31:0] PC_In;
  logic [2:0]  Flags_In;
  logic        Mem_Ack;
  logic [15:0] Mem_Data_In;

  logic        Stall_Fetch;
  logic        Flush_Decode;
  logic        Inject_Valid;
  logic [2:0]  Inject_Op;
  logic [15:0] Inject_Data;
  logic        PC_Load;
  logic [31:0] PC_Out;
  logic        Flags_Load;
  logic [2:0]  Flags_Out;

  modport master (
    input  INT_Req, RTI_Dec, Pipe_Busy, PC_In, Flags_In, Mem_Ack, Mem_Data_In,
    output Stall_Fetch, Flush_Decode, Inject_Valid, Inject_Op, Inject_Data,
           PC_Load, PC_Out, Flags_Load, Flags_Out
  );

  modport slave (
    output INT_Req, RTI_Dec, Pipe_Busy, PC_In, Flags_In, Mem_Ack, Mem_Data_In,
    input  Stall_Fetch, Flush_Decode, Inject_Valid, Inject_Op, Inject_Data,
           PC_Load, PC_Out, Flags_Load, Flags_Out
  );

endinterface

// File: rtl/interrupt_sequencer_int_pending.sv
// Interrupt request edge detector and pending latch.
module int_pending (
  input  logic clk,
  input  logic rst,
  input  logic int_req,
  input  logic clr,
  output logic pending,
  output logic rise
);

  logic int_req_d_reg;

  assign rise = int_req & ~int_req_d_reg;

  // The delayed copy resets to 1 so a request already high across reset
  // is not mistaken for a fresh edge; a new edge wins over a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      int_req_d_reg <= 1'b1;
      pending       <= 1'b0;
    end else begin
      int_req_d_reg <= int_req;
      if (rise)
        pending <= 1'b1;
      else if (clr)
        pending <= 1'b0;
    end
  end

endmodule

// File: rtl/interrupt_sequencer.sv
// Interrupt entry / RTI return sequencer: stalls fetch, drains the pipe,
// injects stack micro-ops and finally loads PC (and flags on return).
module interrupt_sequencer
  import interrupt_sequencer_pkg::*;
#(
  parameter int          DRAIN_CYCLES = 3,
  parameter logic [15:0] VEC_ADDR     = 16'h0000
) (
  input logic                   clk,
  input logic                   rst,
  interrupt_sequencer_if.master bus
);

  state_t             state_reg;
  dir_t               dir_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [31:0]        pc_reg;     // return PC captured on entry
  logic [31:0]        tgt_reg;    // assembled jump target
  logic [2:0]         flags_reg;

  logic pending;
  logic rise;
  logic clr_pending;
  logic idle;
  logic take_entry;
  logic take_return;
  logic hold_rti;

  // Pending is consumed once the drain completes on the entry path.
  assign clr_pending = (state_reg == ST_DRAIN) && (cnt_reg == '0) && (dir_reg == DIR_ENTRY);

  int_pending u_int_pending (
    .clk     (clk),
    .rst     (rst),
    .int_req (bus.INT_Req),
    .clr     (clr_pending),
    .pending (pending),
    .rise    (rise)
  );

  // An edge arriving alongside RTI_Dec holds the RTI in decode for one cycle
  // so the interrupt (pending next cycle) takes priority and uses its address.
  assign idle        = (state_reg == ST_IDLE);
  assign take_entry  = idle && pending && !bus.Pipe_Busy;
  assign take_return = idle && !take_entry && bus.RTI_Dec && !rise;
  assign hold_rti    = idle && !take_entry && bus.RTI_Dec && rise;

  // Sequencer state, direction, drain counter and captured words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      dir_reg   <= DIR_ENTRY;
      cnt_reg   <= '0;
      pc_reg    <= '0;
      tgt_reg   <= '0;
      flags_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (take_entry) begin
            state_reg <= ST_DRAIN;
            dir_reg   <= DIR_ENTRY;
            cnt_reg   <= CNT_W'(DRAIN_CYCLES - 1);
            pc_reg    <= bus.PC_In;
            flags_reg <= bus.Flags_In;
          end else if (take_return) begin
            state_reg <= ST_DRAIN;
            dir_reg   <= DIR_RETURN;
            cnt_reg   <= CNT_W'(DRAIN_CYCLES - 1);
          end
        end
        ST_DRAIN: begin
          if (cnt_reg == '0)
            state_reg <= (dir_reg == DIR_ENTRY) ? ST_PUSH_HI : ST_POP_FL;
          else
            cnt_reg <= cnt_reg - 1'b1;
        end
        ST_PUSH_HI: if (bus.Mem_Ack) state_reg <= ST_PUSH_LO;
        ST_PUSH_LO: if (bus.Mem_Ack) state_reg <= ST_PUSH_FL;
        ST_PUSH_FL: if (bus.Mem_Ack) state_reg <= ST_VEC_LO;
        ST_VEC_LO: begin
          if (bus.Mem_Ack) begin
            tgt_reg[15:0] <= bus.Mem_Data_In;
            state_reg     <= ST_VEC_HI;
          end
        end
        ST_VEC_HI: begin
          if (bus.Mem_Ack) begin
            tgt_reg[31:16] <= bus.Mem_Data_In;
            state_reg      <= ST_JUMP;
          end
        end
        ST_POP_FL: begin
          if (bus.Mem_Ack) begin
            flags_reg[FLAG_NF] <= bus.Mem_Data_In[FLAG_NF];
            flags_reg[FLAG_CF] <= bus.Mem_Data_In[FLAG_CF];
            flags_reg[FLAG_ZF] <= bus.Mem_Data_In[FLAG_ZF];
            state_reg          <= ST_POP_LO;
          end
        end
        ST_POP_LO: begin
          if (bus.Mem_Ack) begin
            tgt_reg[15:0] <= bus.Mem_Data_In;
            state_reg     <= ST_POP_HI;
          end
        end
        ST_POP_HI: begin
          if (bus.Mem_Ack) begin
            tgt_reg[31:16] <= bus.Mem_Data_In;
            state_reg      <= ST_JUMP;
          end
        end
        ST_JUMP: state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  logic        inj_valid;
  logic [2:0]  inj_op;
  logic [15:0] inj_data;

  // Micro-op presented to ID/EX for each memory state; held until acked.
  always_comb begin
    inj_valid = 1'b0;
    inj_op    = OP_NONE;
    inj_data  = 16'h0000;
    case (state_reg)
      ST_PUSH_HI: begin inj_valid = 1'b1; inj_op = OP_PUSH; inj_data = pc_reg[31:16];         end
      ST_PUSH_LO: begin inj_valid = 1'b1; inj_op = OP_PUSH; inj_data = pc_reg[15:0];          end
      ST_PUSH_FL: begin inj_valid = 1'b1; inj_op = OP_PUSH; inj_data = flags_word(flags_reg); end
      ST_VEC_LO:  begin inj_valid = 1'b1; inj_op = OP_LOAD; inj_data = VEC_ADDR;              end
      ST_VEC_HI:  begin inj_valid = 1'b1; inj_op = OP_LOAD; inj_data = VEC_ADDR + 16'd1;      end
      ST_POP_FL, ST_POP_LO, ST_POP_HI: begin inj_valid = 1'b1; inj_op = OP_POP;              end
      default: ;
    endcase
  end

  assign bus.Inject_Valid = inj_valid;
  assign bus.Inject_Op    = inj_op;
  assign bus.Inject_Data  = inj_data;

  assign bus.Stall_Fetch  = !idle || take_entry || take_return || hold_rti;
  assign bus.Flush_Decode = (state_reg == ST_JUMP) || take_entry || take_return;
  assign bus.PC_Load      = (state_reg == ST_JUMP);
  assign bus.PC_Out       = (state_reg == ST_JUMP) ? tgt_reg : 32'h0;
  assign bus.Flags_Load   = (state_reg == ST_JUMP) && (dir_reg == DIR_RETURN);
  assign bus.Flags_Out    = bus.Flags_Load ? flags_reg : 3'b000;

endmodule

// File: doc/interrupt_sequencer.md
# interrupt_sequencer

Multi-cycle controller that services external interrupts and RTI returns for the 5-stage pipeline. It stalls fetch and drains in-flight instructions, then injects stack micro-ops through the execution and memory stages. Entry pushes PC (hi, lo) and flags, then loads the vector; RTI pops them in reverse order. It sits beside decode, drives the fetch-stall/flush lines and the PC/flag load ports, and feeds SP/SPOP-style micro-ops into the ID/EX buffer.

## Interface
- DRAIN_CYCLES, 3: cycles fetch stays stalled before the first micro-op (pipeline depth past decode).
- VEC_ADDR, 16'h0000: word address of vector low half; high half at VEC_ADDR+1.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- INT_Req  in  1  external interrupt request, synchronous to clk; rising edge requests service.
- RTI_Dec  in  1  decode holds an RTI this cycle.
- Pipe_Busy  in  1  EX has a taken jump or memory stage is mid-access; entry deferred while high.
- PC_In  in  32  address of the instruction currently in decode (return PC).
- Flags_In  in  3  architectural flags {NF,CF,ZF}.
- Mem_Ack  in  1  memory stage completed the injected op this cycle.
- Mem_Data_In  in  16  read data, valid with Mem_Ack.
- Stall_Fetch  out  1  hold PC and IF/ID.
- Flush_Decode  out  1  turn decode's instruction into a NOP.
- Inject_Valid  out  1  Inject_Op/Inject_Data valid.
- Inject_Op  out  3  1 PUSH, 2 POP, 3 LOAD (absolute); 0 none.
- Inject_Data  out  16  push data, or address for LOAD.
- PC_Load  out  1  one-cycle load of PC_Out into PC.
- PC_Out  out  32  new PC.
- Flags_Load  out  1  one-cycle load of Flags_Out.
- Flags_Out  out  3  restored flags {NF,CF,ZF}.

## Operation
- Pending latch: set on INT_Req rising edge (registered edge detect); cleared on DRAIN→PUSH_HI transition. An edge during service stays pending and is serviced after return to IDLE.
- States: IDLE, DRAIN, PUSH_HI, PUSH_LO, PUSH_FL, VEC_LO, VEC_HI, POP_FL, POP_LO, POP_HI, JUMP. One direction bit (entry/return) is held through DRAIN and JUMP.
- IDLE: if pending & !Pipe_Busy → DRAIN (entry), capturing PC_In and Flags_In. Else if RTI_Dec → DRAIN (return). Pending beats RTI_Dec in the same cycle; the RTI is flushed and its address becomes the return PC.
- DRAIN: counter loads DRAIN_CYCLES-1 and counts to 0, then → PUSH_HI (entry) or POP_FL (return).
- Each memory state holds Inject_Valid and a constant Inject_Op/Inject_Data until Mem_Ack, then advances.
  - PUSH_HI: PC[31:16]. PUSH_LO: PC[15:0]. PUSH_FL: {13'b0,flags}. Then → VEC_LO.
  - VEC_LO/VEC_HI: LOAD with Inject_Data = VEC_ADDR and VEC_ADDR+1; Mem_Data_In is captured into the target register halves. Then → JUMP.
  - POP_FL: capture Mem_Data_In[2:0]. POP_LO: capture PC[15:0]. POP_HI: capture PC[31:16]. Then → JUMP.
- JUMP: PC_Load=1 with the assembled target. Return also sets Flags_Load=1. Next state is IDLE.
- Stall_Fetch=1 in every state except IDLE. Flush_Decode=1 in the IDLE→DRAIN transition cycle and in JUMP.

## Timing
- Reset: state IDLE, pending 0, counter 0, captured registers 0. All outputs 0.
- Outputs are Moore decodes of registered state. Stall_Fetch/Flush_Decode on the departure cycle are Mealy on IDLE inputs.
- INT_Req edge sampled at edge N: pending=1 after N. DRAIN entered at edge N+1 if !Pipe_Busy.
- With Mem_Ack always high, entry takes DRAIN_CYCLES+5+1 cycles (9 at default). Return takes DRAIN_CYCLES+3+1 (7).
- Mem_Ack while Inject_Valid=0 is ignored.
- Async reset mid-sequence aborts immediately to IDLE. Partially pushed stack words are not rolled back.

## Structure
- Package interrupt_sequencer_pkg: state enum, Inject_Op encodings (OP_NONE/PUSH/POP/LOAD), and flag bit positions NF=2, CF=1, ZF=0.
- One sub-module, int_pending: edge detector plus pending set/clear latch.

## Test plan
- Entry: PC_In=32'h0001_0020, Flags_In=3'b101, INT_Req pulse, Mem_Ack=1, vector words 16'h0100/16'h0000.
  - Pushes 16'h0001, 16'h0020, 16'h0005.
  - Loads addresses 0 and 1.
  - PC_Load with PC_Out=32'h0000_0100 at cycle 9 after DRAIN entry.
- RTI pops 16'h0005, 16'h0020, 16'h0001 → PC_Out=32'h0001_0020, Flags_Out=3'b101, PC_Load=Flags_Load=1 in the same cycle.
- Pipe_Busy high 4 cycles after INT_Req → DRAIN entry delayed exactly 4 cycles, pending stays 1.
- Mem_Ack withheld 3 cycles in PUSH_LO → Inject_Data holds 16'h0020 stable, state unchanged, no extra push.
- INT_Req edge and RTI_Dec in the same cycle → entry sequence runs, Flush_Decode=1, return PC = RTI address. A second INT_Req during VEC_HI is serviced right after JUMP.
- rst asserted in PUSH_FL → all outputs 0 at once. After release, idle until a new INT_Req edge.
